// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller in front of a big-endian, byte-addressed,
// word-write-only data memory. Byte stores are done as read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_n,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_load,
  output logic [3:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [7:0]  bdata_q;
  logic [3:0]  rd_q;
  logic        load_q;
  logic        byte_q;

  logic        req_ready_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_wr_n_q;
  logic        resp_valid_q;
  logic        resp_load_q;
  logic [3:0]  resp_rd_q;
  logic [31:0] resp_data_q;
  logic        resp_fault_q;

  logic [31:0] acc_word;
  logic [1:0]  acc_lane;
  logic [32:0] acc_end;
  logic        acc_fault;
  logic [7:0]  rd_byte;
  logic [31:0] merged;

  // Accept-time address split and fault decision for the incoming request
  always_comb begin
    acc_word  = {req_addr[31:2], 2'b00};
    acc_lane  = req_addr[1:0];
    acc_end   = {1'b0, acc_word} + 33'd3;
    acc_fault = (!req_byte && (acc_lane != 2'd0)) || (acc_end >= 33'(MEM_SIZE));
  end

  // Big-endian lane select for byte loads and lane merge for byte stores
  always_comb begin
    rd_byte = '0;
    merged  = mem_rdata;
    unique case (lane_q)
      2'd0: begin rd_byte = mem_rdata[31:24]; merged[31:24] = bdata_q; end
      2'd1: begin rd_byte = mem_rdata[23:16]; merged[23:16] = bdata_q; end
      2'd2: begin rd_byte = mem_rdata[15:8];  merged[15:8]  = bdata_q; end
      2'd3: begin rd_byte = mem_rdata[7:0];   merged[7:0]   = bdata_q; end
    endcase
  end

  // Controller FSM; every memory-side and response output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      bdata_q      <= '0;
      rd_q         <= '0;
      load_q       <= 1'b0;
      byte_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_n_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            lane_q      <= acc_lane;
            bdata_q     <= req_data[7:0];
            rd_q        <= req_rd;
            load_q      <= req_load;
            byte_q      <= req_byte;
            req_ready_q <= 1'b0;
            if (acc_fault) begin
              // Faults skip the memory entirely and respond on the next cycle
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_load_q  <= req_load;
              resp_rd_q    <= req_rd;
              resp_data_q  <= '0;
              state_q      <= S_RESP;
            end else if (!req_load && !req_byte) begin
              mem_addr_q  <= acc_word;
              mem_wdata_q <= req_data;
              mem_wr_n_q  <= 1'b0;
              state_q     <= S_WRITE;
            end else begin
              mem_addr_q  <= acc_word;
              mem_wr_n_q  <= 1'b1;
              state_q     <= S_READ;
            end
          end
        end
        S_READ: begin
          if (load_q) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_load_q  <= 1'b1;
            resp_rd_q    <= rd_q;
            resp_data_q  <= byte_q ? {24'd0, rd_byte} : mem_rdata;
            state_q      <= S_RESP;
          end else begin
            mem_wdata_q <= merged;
            mem_wr_n_q  <= 1'b0;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_wr_n_q   <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_load_q  <= load_q;
          resp_rd_q    <= rd_q;
          resp_data_q  <= '0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wr_n   = mem_wr_n_q;
  assign resp_valid = resp_valid_q;
  assign resp_load  = resp_load_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural data memory and a
// byte-array reference model of memory contents.
module tb_mem_access_unit;

  localparam int unsigned MEM_SIZE = 32;
  localparam int unsigned NWORDS   = MEM_SIZE / 4;
  localparam int unsigned WIDX_W   = $clog2(NWORDS);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_rd = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_n;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_load;
  logic [3:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_fault;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_SIZE(MEM_SIZE)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_load  (req_load),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rd    (req_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_n  (mem_wr_n),
    .mem_rdata (mem_rdata),
    .resp_valid(resp_valid),
    .resp_load (resp_load),
    .resp_rd   (resp_rd),
    .resp_data (resp_data),
    .resp_fault(resp_fault)
  );

  // Behavioural data memory: combinational read, word write on negedge
  logic [31:0]       dmem [NWORDS];
  logic [WIDX_W-1:0] widx;
  assign widx = mem_addr[WIDX_W+1:2];

  initial for (int i = 0; i < int'(NWORDS); i++) dmem[i] = '0;

  always_comb begin
    mem_rdata = '0;
    if (mem_addr < MEM_SIZE) mem_rdata = dmem[widx];
  end

  always @(negedge clk) begin
    if (!mem_wr_n && (mem_addr < MEM_SIZE)) dmem[widx] <= mem_wdata;
  end

  // Reference model and scoreboard
  logic [7:0] refm [MEM_SIZE];
  initial for (int i = 0; i < int'(MEM_SIZE); i++) refm[i] = '0;

  typedef struct {
    bit        load;
    bit [3:0]  rd;
    bit [31:0] data;
    bit        fault;
    int        lat;
    int        nwr;
    bit [31:0] wdata;
    int        acc_cyc;
  } exp_t;

  exp_t sbq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_issued = 0;
  int n_resp = 0;
  int wr_cnt = 0;
  int wr_prev = 0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts write strobes and checks every response against the queue
  always @(negedge clk) begin
    exp_t e;
    if (!mem_wr_n) begin
      wr_cnt++;
      last_wdata = mem_wdata;
      chk("wr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
    end
    if (resp_valid) begin
      n_resp++;
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response pending");
      end else begin
        e = sbq.pop_front();
        chk("resp_fault", 32'(resp_fault), 32'(e.fault));
        chk("resp_data", resp_data, e.data);
        chk("resp_rd", 32'(resp_rd), 32'(e.rd));
        if (!e.fault) chk("resp_load", 32'(resp_load), 32'(e.load));
        chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        chk("nwrites", 32'(wr_cnt - wr_prev), 32'(e.nwr));
        if (e.nwr != 0) chk("wdata", last_wdata, e.wdata);
        chk("resp_ready", 32'(req_ready), 32'd0);
      end
      wr_prev = wr_cnt;
    end
  end

  // Issue one request starting at a negedge; returns at the negedge after accept
  task automatic issue(input bit ld, input bit byt, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] rd);
    exp_t e;
    int   a;
    int   lane;
    int   waited;
    req_valid = 1'b1;
    req_load  = ld;
    req_byte  = byt;
    req_addr  = addr;
    req_data  = data;
    req_rd    = rd;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
      req_valid = 1'b0;
      return;
    end
    a    = int'(addr) & ~3;
    lane = int'(addr[1:0]);
    e.load    = ld;
    e.rd      = rd;
    e.data    = '0;
    e.nwr     = 0;
    e.wdata   = '0;
    e.fault   = (!byt && lane != 0) || (a + 3 >= int'(MEM_SIZE));
    e.acc_cyc = cyc + 1;
    if (e.fault) begin
      e.lat = 1;
    end else if (ld) begin
      e.lat = 2;
      if (byt) e.data = {24'd0, refm[a + lane]};
      else     e.data = {refm[a], refm[a + 1], refm[a + 2], refm[a + 3]};
    end else if (!byt) begin
      e.lat = 2;
      e.nwr = 1;
      e.wdata = data;
      refm[a] = data[31:24]; refm[a + 1] = data[23:16];
      refm[a + 2] = data[15:8]; refm[a + 3] = data[7:0];
    end else begin
      e.lat = 3;
      e.nwr = 1;
      refm[a + lane] = data[7:0];
      e.wdata = {refm[a], refm[a + 1], refm[a + 2], refm[a + 3]};
    end
    sbq.push_back(e);
    n_issued++;
    @(negedge clk);
    chk("busy_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_mem_wr_n"},   32'(mem_wr_n),   32'd1);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_load"},  32'(resp_load),  32'd0);
    chk({tag, "_resp_rd"},    32'(resp_rd),    32'd0);
    chk({tag, "_resp_data"},  resp_data,       32'd0);
    chk({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sbq.size() != 0 || !req_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d responses pending expected 0", sbq.size());
    end
  endtask

  initial begin
    int wr_snap;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_snap;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Word store then load
    issue(1'b0, 1'b0, 32'd8, 32'hDEADBEEF, 4'd0);
    issue(1'b1, 1'b0, 32'd8, 32'h0, 4'd3);
    // Byte load lanes
    issue(1'b0, 1'b0, 32'd4, 32'h11223344, 4'd0);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 32'(4 + i), 32'hFFFFFFFF, 4'(i + 1));
    // Byte store read-modify-write
    issue(1'b0, 1'b0, 32'd12, 32'hAABBCCDD, 4'd0);
    issue(1'b0, 1'b1, 32'd14, 32'h1234565A, 4'd9);
    issue(1'b1, 1'b0, 32'd12, 32'h0, 4'd10);
    // Faults: misaligned word load and out-of-range store
    issue(1'b1, 1'b0, 32'd6, 32'h0, 4'd5);
    issue(1'b0, 1'b0, 32'd32, 32'h01020304, 4'd6);
    // Untouched memory reads as zero; byte store merges into zero
    issue(1'b1, 1'b0, 32'd28, 32'h0, 4'd11);
    issue(1'b0, 1'b1, 32'd25, 32'h000000C3, 4'd0);
    issue(1'b1, 1'b0, 32'd24, 32'h0, 4'd12);
    req_valid = 1'b0;
    drain();

    // Reset during the READ of a byte store aborts it
    issue(1'b0, 1'b0, 32'd20, 32'hCAFEF00D, 4'd0);
    req_valid = 1'b0;
    drain();
    req_valid = 1'b1;
    req_load  = 1'b0;
    req_byte  = 1'b1;
    req_addr  = 32'd21;
    req_data  = 32'h00000077;
    req_rd    = 4'd0;
    @(negedge clk);              // accepted at the posedge before this
    req_valid = 1'b0;
    rst = 1'b1;
    wr_snap = wr_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - wr_snap), 32'd0);
    chk("abort_idle_ready", 32'(req_ready), 32'd1);
    issue(1'b1, 1'b0, 32'd20, 32'h0, 4'd7);
    req_valid = 1'b0;
    drain();

    // Randomized traffic, mostly back-to-back with occasional idle gaps
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, MEM_SIZE + 7)), $urandom, 4'($urandom_range(0, 15)));
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    chk("resp_count", 32'(n_resp), 32'(n_issued));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller sitting directly upstream of the data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and performs word and byte LDR/STR against the big-endian, byte-addressed data memory.
- The data memory only writes whole words, so byte stores are done as read-modify-write.
- Returns load data and completion/fault status to writeback.

Parameters:
- MEM_SIZE, 32, data memory size in bytes; must equal the data memory's size parameter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_load  in  1  1 = load, 0 = store.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  32  byte address.
- req_data  in  32  store data; for byte stores only [7:0] is used.
- req_rd  in  4  destination register for loads.
- mem_addr  out  32  address to data memory; always word-aligned.
- mem_wdata  out  32  write data to data memory.
- mem_wr_n  out  1  active-low write enable; memory commits on negedge.
- mem_rdata  in  32  combinational read data from memory.
- resp_valid  out  1  one-cycle completion pulse.
- resp_load  out  1  completed op was a load (writeback required).
- resp_rd  out  4  destination register.
- resp_data  out  32  load result; zero for stores and faults.
- resp_fault  out  1  access faulted; no memory write occurred.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Memory-side outputs and resp_* decode only from registered state and latched request. There is no combinational path from req_* to them.
- Reset (sync): state IDLE. req_ready=1, mem_wr_n=1, mem_addr=0, mem_wdata=0, resp_valid=0, resp_load=0, resp_rd=0, resp_data=0, resp_fault=0.
- IDLE:
  - req_ready=1.
  - On req_valid at posedge, latch addr, data, rd, load and byte.
  - Compute A = addr & ~3 and lane = addr[1:0].
- Fault check, done at accept:
  - Word access with lane != 0, or A+3 >= MEM_SIZE, is a fault.
  - A fault goes to RESP with fault=1 and issues no memory cycle.
- Next state after accept, no fault:
  - Word store: WRITE.
  - All loads and byte stores: READ.
- READ (1 cycle):
  - mem_addr=A, mem_wr_n=1.
  - mem_rdata is captured at the posedge ending the cycle.
  - Loads then go to RESP.
  - Byte stores then go to WRITE with a merged word: the rdata lane replaced by data[7:0].
- Byte lanes are big-endian: lane0=[31:24], lane1=[23:16], lane2=[15:8], lane3=[7:0].
- Byte load result = zero-extended selected lane.
- WRITE (1 cycle):
  - mem_addr=A, mem_wr_n=0.
  - mem_wdata = req_data for a word store, or the merged word for a byte store.
  - Then go to RESP.
- RESP (1 cycle):
  - resp_valid=1, req_ready=0.
  - resp_data = load result, else 0.
  - Then go to IDLE.
- resp_* hold their values until the next RESP. resp_valid is 0 outside RESP.
- Latency, counting the accept edge as cycle 0, resp_valid asserts in:
  - Fault: cycle 1.
  - Word store and all loads: cycle 2.
  - Byte store: cycle 3.
- Throughput: req_ready=0 from accept until back in IDLE. Next accept can occur in the cycle after RESP.
- Memory returns 0 for uninitialised words. A load of untouched memory yields 0, and a byte store into untouched memory merges into 0.
- rst during READ/WRITE/RESP aborts to IDLE with no resp_valid. mem_wr_n=1 from the cycle after the reset edge. A WRITE cycle whose negedge has already passed remains committed.
- rst has priority over req_valid.

Test Plan:
- Word store then load: STR 0xDEADBEEF @8; LDR @8, rd=3 -> store resp at cycle 2 with resp_load=0. Load resp_data=0xDEADBEEF, resp_rd=3, mem_wr_n low exactly one cycle.
- Byte load lanes: memory @4 = 0x11223344; LDRB @4,5,6,7 -> resp_data 0x11, 0x22, 0x33, 0x44, each zero-extended.
- Byte store RMW: @12 = 0xAABBCCDD; STRB 0x5A @14 -> READ then WRITE with mem_wdata=0xAABB5ADD. resp at cycle 3; LDR @12 returns 0xAABB5ADD.
- Faults: LDR @6 (misaligned) and STR @32 (MEM_SIZE=32) -> resp_fault=1 at cycle 1, resp_data=0, mem_wr_n never low.
- Handshake: req_valid held high with back-to-back requests -> req_ready=0 while busy. Each request is accepted exactly once and resp_valid pulses once per request.
- Reset mid-operation: assert rst in READ of a byte store -> no WRITE cycle, no resp_valid. Memory unchanged; req_ready=1 and all outputs at reset values next cycle.
